// File: rtl/axi_l2_write_monitor.sv
// Passive AXI AW/W monitor between the tile data port and L2 simulation memory.
// Pairs W beats with their AW bursts and decodes stdout/stderr/EOC writes.

module axi_l2_wm_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

endmodule

module axi_l2_write_monitor #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] STDERR_ADDR = 32'h2FFF_0000,
  parameter logic [31:0] STDOUT_ADDR = 32'h2FFF_0004,
  parameter logic [31:0] EOC_ADDR    = 32'h2C03_0000,
  parameter int unsigned TAG_DEPTH   = 4,
  parameter int unsigned WDAT_DEPTH  = 4,
  parameter int unsigned CHAR_DEPTH  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                aw_valid_i,
  input  logic                aw_ready_i,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  input  logic [7:0]          aw_len_i,
  input  logic                w_valid_i,
  input  logic                w_ready_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  input  logic                w_last_i,
  output logic                char_valid_o,
  input  logic                char_ready_i,
  output logic [7:0]          char_o,
  output logic                err_valid_o,
  output logic [7:0]          err_code_o,
  output logic                eoc_o,
  output logic [31:0]         exit_code_o,
  output logic                fault_o,
  output logic                char_drop_o
);

  typedef enum logic [1:0] {K_OTHER, K_STDERR, K_STDOUT, K_EOC} kind_e;
  typedef enum logic {S_RUN, S_FAULT} state_e;

  typedef struct packed {
    kind_e      kind;
    logic [7:0] len;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              strb0;
    logic              last;
  } wbeat_t;

  localparam int unsigned TAG_W = $bits(tag_t);
  localparam int unsigned WB_W  = $bits(wbeat_t);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              act_valid_q, act_valid_d;
  kind_e             act_kind_q, act_kind_d;
  logic [DATA_W-1:0] act_data_q, act_data_d;
  logic              act_strb_q, act_strb_d;
  logic              err_valid_q, err_valid_d;
  logic [7:0]        err_code_q, err_code_d;
  logic              eoc_q, eoc_d;
  logic [31:0]       exit_q, exit_d;
  logic              drop_q, drop_d;

  tag_t   tag_in, tag_head;
  wbeat_t wb_in, wb_head;
  logic   tag_push, tag_pop, tag_empty, tag_full;
  logic   wb_push, wb_pop, wb_empty, wb_full;
  logic   char_push, char_pop, char_empty, char_full;
  logic [7:0] char_head;
  logic   pair, last_beat, len_err, overflow;
  logic   unused_strb;

  assign unused_strb = ^w_strb_i;

  axi_l2_wm_fifo #(.WIDTH(TAG_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(tag_push), .pop_i(tag_pop),
    .data_i(tag_in), .data_o(tag_head), .empty_o(tag_empty), .full_o(tag_full)
  );

  axi_l2_wm_fifo #(.WIDTH(WB_W), .DEPTH(WDAT_DEPTH)) u_wdat_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(wb_push), .pop_i(wb_pop),
    .data_i(wb_in), .data_o(wb_head), .empty_o(wb_empty), .full_o(wb_full)
  );

  axi_l2_wm_fifo #(.WIDTH(8), .DEPTH(CHAR_DEPTH)) u_char_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(char_push), .pop_i(char_pop),
    .data_i(act_data_q[7:0]), .data_o(char_head), .empty_o(char_empty), .full_o(char_full)
  );

  // Capture, pairing and fault detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tag_in    = '{kind: K_OTHER, len: aw_len_i};
    wb_in     = '{data: w_data_i, strb0: w_strb_i[0], last: w_last_i};
    tag_push  = 1'b0;
    wb_push   = 1'b0;
    pair      = 1'b0;
    last_beat = 1'b0;
    len_err   = 1'b0;
    tag_pop   = 1'b0;
    wb_pop    = 1'b0;
    overflow  = 1'b0;

    if (aw_addr_i == ADDR_W'(STDERR_ADDR))      tag_in.kind = K_STDERR;
    else if (aw_addr_i == ADDR_W'(STDOUT_ADDR)) tag_in.kind = K_STDOUT;
    else if (aw_addr_i == ADDR_W'(EOC_ADDR))    tag_in.kind = K_EOC;

    if (state_q == S_RUN) begin
      tag_push  = aw_valid_i & aw_ready_i;
      wb_push   = w_valid_i & w_ready_i;
      pair      = ~tag_empty & ~wb_empty;
      last_beat = (cnt_q == tag_head.len);
      len_err   = pair & (wb_head.last != last_beat);
      wb_pop    = pair;
      tag_pop   = pair & last_beat;
      overflow  = (tag_push & tag_full & ~tag_pop) | (wb_push & wb_full & ~wb_pop);
      if (pair) cnt_d = last_beat ? 8'd0 : cnt_q + 8'd1;
      if (overflow || len_err) state_d = S_FAULT;
    end
  end

  // Paired-beat stage and decode of the registered beat into outputs.
  always_comb begin
    act_valid_d = pair & ~len_err;
    act_kind_d  = tag_head.kind;
    act_data_d  = wb_head.data;
    act_strb_d  = wb_head.strb0;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    eoc_d       = eoc_q;
    exit_d      = exit_q;
    drop_d      = drop_q;

    char_pop  = ~char_empty & char_ready_i;
    char_push = act_valid_q & act_strb_q & (act_kind_q == K_STDOUT);
    if (char_push && char_full && !char_pop) drop_d = 1'b1;

    if (act_valid_q && act_strb_q && act_kind_q == K_STDERR) begin
      err_valid_d = 1'b1;
      err_code_d  = act_data_q[7:0];
    end

    if (act_valid_q && act_strb_q && act_kind_q == K_EOC && act_data_q != '0 && !eoc_q) begin
      eoc_d  = 1'b1;
      exit_d = 32'(act_data_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      act_valid_q <= 1'b0;
      act_kind_q  <= K_OTHER;
      act_data_q  <= '0;
      act_strb_q  <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      eoc_q       <= 1'b0;
      exit_q      <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_valid_q <= act_valid_d;
      act_kind_q  <= act_kind_d;
      act_data_q  <= act_data_d;
      act_strb_q  <= act_strb_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      eoc_q       <= eoc_d;
      exit_q      <= exit_d;
      drop_q      <= drop_d;
    end
  end

  assign char_valid_o = ~char_empty;
  assign char_o       = char_empty ? 8'd0 : char_head;
  assign err_valid_o  = err_valid_q;
  assign err_code_o   = err_code_q;
  assign eoc_o        = eoc_q;
  assign exit_code_o  = exit_q;
  assign fault_o      = (state_q == S_FAULT);
  assign char_drop_o  = drop_q;

endmodule
